// File: rtl/spi_slave_rx_if.sv
// Command handshake bundle between the SPI receiver and its consumer.
//   CMD_OUT   : last accepted command word (producer -> consumer)
//   CMD_VALID : CMD_OUT holds an unacknowledged word (producer -> consumer)
//   CMD_ACK   : consumer acknowledge, sampled on the producer clock
interface spi_slave_rx_if #(
    parameter int unsigned CMD_W = 16
);
    logic [CMD_W-1:0] CMD_OUT;
    logic             CMD_VALID;
    logic             CMD_ACK;

    // Receiver side: drives the word and its valid flag.
    modport master (
        output CMD_OUT,
        output CMD_VALID,
        input  CMD_ACK
    );

    // Consumer side: reads the word and acknowledges it.
    modport slave (
        input  CMD_OUT,
        input  CMD_VALID,
        output CMD_ACK
    );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI slave command receiver, oversampled by CLK (at least 4x SCLK).
// All SPI-side inputs are asynchronous and pass through 2-flop synchronizers.
// A frame is framed by CSb low, carries CMD_W bits MSB first (sampled on SCLK
// rise), and is delivered on the CSb rising edge if it had exactly CMD_W bits.
//
// Ports:
//   CLK, RST    : block clock, synchronous active-low reset
//   SCLK, CSb,
//   MOSI        : SPI master signals (asynchronous)
//   RST_SLV     : master-driven soft reset, active high (asynchronous)
//   TRG_SLV     : master-driven trigger level (asynchronous)
//   cmd         : command handshake (CMD_OUT / CMD_VALID / CMD_ACK)
//   FRAME_ERR   : one-cycle pulse on a short or over-length frame
//   OVERRUN     : one-cycle pulse when a good frame is dropped
//   TRG_OUT     : synchronized TRG_SLV level
//   TRG_PULSE   : one-cycle pulse on a TRG_OUT rising edge
//   BUSY        : a frame is being received (RECV or OVRLEN)
module spi_slave_rx #(
    parameter int unsigned CMD_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SCLK,
    input  logic              CSb,
    input  logic              MOSI,
    input  logic              RST_SLV,
    input  logic              TRG_SLV,
    spi_slave_rx_if.master    cmd,
    output logic              FRAME_ERR,
    output logic              OVERRUN,
    output logic              TRG_OUT,
    output logic              TRG_PULSE,
    output logic              BUSY
);

    // Counter must reach CMD_W+1 (the first over-length SCLK rise).
    localparam int unsigned CNT_W = $clog2(CMD_W + 2);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RECV   = 2'd1;
    localparam logic [1:0] ST_OVRLEN = 2'd2;

    // Synchronizer flops.
    logic sclk_s1, sclk_s2, sclk_s3;
    logic csb_s1,  csb_s2,  csb_s3;
    logic mosi_s1, mosi_s2;
    logic rslv_s1, rslv_s2;
    logic trg_s1;

    // Counts synchronizer fill after RST so stale reset values are never
    // mistaken for a real CSb level.
    logic [1:0] sync_fill_q;
    // Set once CSb has been seen high; a falling edge only counts when armed.
    logic       armed_q;

    logic              core_rst;
    logic              sclk_rise;
    logic              csb_rise;
    logic              csb_fall;

    logic [1:0]        state_q,     state_d;
    logic [CMD_W-1:0]  shift_q,     shift_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [CMD_W-1:0]  cmd_out_q,   cmd_out_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              frame_err_d;
    logic              overrun_d;
    logic              deliver;

    // Input synchronizers; cleared by RST only so the soft reset can release.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            csb_s1  <= 1'b1;
            csb_s2  <= 1'b1;
            csb_s3  <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            rslv_s1 <= 1'b0;
            rslv_s2 <= 1'b0;
            sync_fill_q <= 2'd0;
        end else begin
            sclk_s1 <= SCLK;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            csb_s1  <= CSb;
            csb_s2  <= csb_s1;
            csb_s3  <= csb_s2;
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;
            rslv_s1 <= RST_SLV;
            rslv_s2 <= rslv_s1;
            if (sync_fill_q != 2'd2) begin
                sync_fill_q <= sync_fill_q + 2'd1;
            end
        end
    end

    // Trigger path: unaffected by the soft reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            trg_s1    <= 1'b0;
            TRG_OUT   <= 1'b0;
            TRG_PULSE <= 1'b0;
        end else begin
            trg_s1    <= TRG_SLV;
            TRG_OUT   <= trg_s1;
            TRG_PULSE <= trg_s1 & ~TRG_OUT;
        end
    end

    assign core_rst  = !RST || rslv_s2;
    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign csb_rise  = csb_s2 & ~csb_s3;
    assign csb_fall  = armed_q & ~csb_s2 & csb_s3;

    // Arm once a genuine (post-fill) CSb high level has been observed.
    always_ff @(posedge CLK) begin
        if (core_rst) begin
            armed_q <= 1'b0;
        end else if ((sync_fill_q == 2'd2) && csb_s2) begin
            armed_q <= 1'b1;
        end
    end

    // Next-state, datapath and handshake decode.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        cmd_out_d   = cmd_out_q;
        cmd_valid_d = cmd_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (csb_fall) begin
                    state_d = ST_RECV;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_RECV: begin
                // End of frame takes priority over a coincident SCLK rise.
                if (csb_rise) begin
                    state_d = ST_IDLE;
                    if (cnt_q == CNT_W'(CMD_W)) begin
                        deliver = 1'b1;
                    end else if (cnt_q != '0) begin
                        frame_err_d = 1'b1;
                    end
                end else if (sclk_rise) begin
                    shift_d = {shift_q[CMD_W-2:0], mosi_s2};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(CMD_W)) begin
                        state_d = ST_OVRLEN;
                    end
                end
            end
            ST_OVRLEN: begin
                if (csb_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A coincident ACK frees the slot for the new word.
        if (deliver) begin
            if (!cmd_valid_q || cmd.CMD_ACK) begin
                cmd_out_d   = shift_q;
                cmd_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (cmd_valid_q && cmd.CMD_ACK) begin
            cmd_valid_d = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (core_rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            cmd_out_q   <= '0;
            cmd_valid_q <= 1'b0;
            FRAME_ERR   <= 1'b0;
            OVERRUN     <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            cmd_out_q   <= cmd_out_d;
            cmd_valid_q <= cmd_valid_d;
            FRAME_ERR   <= frame_err_d;
            OVERRUN     <= overrun_d;
            BUSY        <= (state_d != ST_IDLE);
        end
    end

    assign cmd.CMD_OUT   = cmd_out_q;
    assign cmd.CMD_VALID = cmd_valid_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: frame table plus hand sequences for reset,
// delivery latency, soft reset, mid-frame reset and the trigger path.
module tb_spi_slave_rx;

    logic CLK = 1'b0;
    logic RST, SCLK, CSb, MOSI, RST_SLV, TRG_SLV;
    logic FRAME_ERR, OVERRUN, TRG_OUT, TRG_PULSE, BUSY;

    spi_slave_rx_if #(.CMD_W(16)) cmd_if ();

    spi_slave_rx #(.CMD_W(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .SCLK      (SCLK),
        .CSb       (CSb),
        .MOSI      (MOSI),
        .RST_SLV   (RST_SLV),
        .TRG_SLV   (TRG_SLV),
        .cmd       (cmd_if),
        .FRAME_ERR (FRAME_ERR),
        .OVERRUN   (OVERRUN),
        .TRG_OUT   (TRG_OUT),
        .TRG_PULSE (TRG_PULSE),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int tp_cnt = 0;

    // Pulse counters, sampled away from the active edge.
    always @(negedge CLK) begin
        if (FRAME_ERR === 1'b1) fe_cnt++;
        if (OVERRUN   === 1'b1) ov_cnt++;
        if (TRG_PULSE === 1'b1) tp_cnt++;
    end

    typedef struct {
        logic [31:0] data;
        int          nbits;
        bit          coinc;
        bit          post_ack;
        logic [15:0] exp_out;
        logic        exp_valid;
        int          exp_fe;
        int          exp_ov;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Clock nbits of data out MSB first with SCLK = CLK/4.
    task automatic send_bits(input logic [31:0] data, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            MOSI = data[i];
            SCLK = 1'b0;
            tick(2);
            SCLK = 1'b1;
            tick(2);
        end
        SCLK = 1'b0;
        tick(2);
    endtask

    task automatic open_frame();
        CSb = 1'b0;
        tick(4);
    endtask

    task automatic ack_pulse();
        cmd_if.CMD_ACK = 1'b1;
        tick(1);
        cmd_if.CMD_ACK = 1'b0;
        tick(1);
    endtask

    initial begin
        int fe0, ov0, tp0;

        vecs[0] = '{32'h0000_0155, 10, 1'b0, 1'b0, 16'hA5C3, 1'b0, 1, 0};
        vecs[1] = '{32'h0001_FFFF, 17, 1'b0, 1'b0, 16'hA5C3, 1'b0, 1, 0};
        vecs[2] = '{32'h0000_1234, 16, 1'b0, 1'b0, 16'h1234, 1'b1, 0, 0};
        vecs[3] = '{32'h0000_BEEF, 16, 1'b0, 1'b1, 16'h1234, 1'b1, 0, 1};
        vecs[4] = '{32'h0000_1234, 16, 1'b0, 1'b0, 16'h1234, 1'b1, 0, 0};
        vecs[5] = '{32'h0000_BEEF, 16, 1'b1, 1'b1, 16'hBEEF, 1'b1, 0, 0};
        vecs[6] = '{32'h0000_0000,  0, 1'b0, 1'b0, 16'hBEEF, 1'b0, 0, 0};
        vecs[7] = '{32'h0000_0001,  1, 1'b0, 1'b0, 16'hBEEF, 1'b0, 1, 0};
        vecs[8] = '{32'h0000_7FFF, 15, 1'b0, 1'b0, 16'hBEEF, 1'b0, 1, 0};
        vecs[9] = '{32'h0000_8001, 16, 1'b0, 1'b1, 16'h8001, 1'b1, 0, 0};

        // Reset with CSb already low and TRG_SLV high.
        RST = 1'b0; SCLK = 1'b0; CSb = 1'b0; MOSI = 1'b0;
        RST_SLV = 1'b0; TRG_SLV = 1'b1; cmd_if.CMD_ACK = 1'b0;
        tick(4);
        check("rst_cmd_out",   32'(cmd_if.CMD_OUT), 32'h0);
        check("rst_cmd_valid", 32'(cmd_if.CMD_VALID), 32'h0);
        check("rst_busy",      32'(BUSY), 32'h0);
        check("rst_frame_err", 32'(FRAME_ERR), 32'h0);
        check("rst_trg_out",   32'(TRG_OUT), 32'h0);
        check("rst_trg_pulse", 32'(TRG_PULSE), 32'h0);
        TRG_SLV = 1'b0;
        RST = 1'b1;

        // CSb low at release: the frame must be ignored until CSb goes high.
        fe0 = fe_cnt;
        tick(4);
        send_bits(32'h0000_FFFF, 16);
        check("csb_low_at_release_busy", 32'(BUSY), 32'h0);
        CSb = 1'b1;
        tick(6);
        check("csb_low_at_release_valid", 32'(cmd_if.CMD_VALID), 32'h0);
        check("csb_low_at_release_fe", 32'(fe_cnt - fe0), 32'h0);

        // Good frame and delivery latency: valid at the 3rd edge seeing CSb high.
        fe0 = fe_cnt;
        open_frame();
        check("a5c3_busy", 32'(BUSY), 32'h1);
        send_bits(32'h0000_A5C3, 16);
        CSb = 1'b1;
        tick(2);
        check("a5c3_valid_edge2", 32'(cmd_if.CMD_VALID), 32'h0);
        tick(1);
        check("a5c3_valid_edge3", 32'(cmd_if.CMD_VALID), 32'h1);
        check("a5c3_cmd_out", 32'(cmd_if.CMD_OUT), 32'hA5C3);
        tick(2);
        check("a5c3_fe", 32'(fe_cnt - fe0), 32'h0);
        ack_pulse();
        check("a5c3_ack_clear", 32'(cmd_if.CMD_VALID), 32'h0);
        check("a5c3_out_kept", 32'(cmd_if.CMD_OUT), 32'hA5C3);

        // Frame table.
        for (int v = 0; v < 10; v++) begin
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            open_frame();
            send_bits(vecs[v].data, vecs[v].nbits);
            CSb = 1'b1;
            if (vecs[v].coinc) begin
                tick(2);
                cmd_if.CMD_ACK = 1'b1;
                tick(1);
                cmd_if.CMD_ACK = 1'b0;
                tick(3);
            end else begin
                tick(6);
            end
            check($sformatf("vec%0d_cmd_out", v), 32'(cmd_if.CMD_OUT), 32'(vecs[v].exp_out));
            check($sformatf("vec%0d_valid", v), 32'(cmd_if.CMD_VALID), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_busy", v), 32'(BUSY), 32'h0);
            check($sformatf("vec%0d_fe", v), 32'(fe_cnt - fe0), 32'(vecs[v].exp_fe));
            check($sformatf("vec%0d_ov", v), 32'(ov_cnt - ov0), 32'(vecs[v].exp_ov));
            if (vecs[v].post_ack) begin
                ack_pulse();
                check($sformatf("vec%0d_ack_clear", v), 32'(cmd_if.CMD_VALID), 32'h0);
            end
        end

        // Soft reset after 8 bits, then a full frame.
        fe0 = fe_cnt;
        open_frame();
        send_bits(32'h0000_00AA, 8);
        RST_SLV = 1'b1;
        tick(4);
        check("softrst_busy", 32'(BUSY), 32'h0);
        check("softrst_cmd_out", 32'(cmd_if.CMD_OUT), 32'h0);
        RST_SLV = 1'b0;
        tick(4);
        CSb = 1'b1;
        tick(6);
        check("softrst_fe", 32'(fe_cnt - fe0), 32'h0);
        check("softrst_valid", 32'(cmd_if.CMD_VALID), 32'h0);
        open_frame();
        send_bits(32'h0000_00FF, 16);
        CSb = 1'b1;
        tick(6);
        check("softrst_next_out", 32'(cmd_if.CMD_OUT), 32'h00FF);
        check("softrst_next_valid", 32'(cmd_if.CMD_VALID), 32'h1);
        ack_pulse();

        // Hard reset mid-frame: partial word dropped, no FRAME_ERR.
        fe0 = fe_cnt;
        open_frame();
        send_bits(32'h0000_001F, 5);
        RST = 1'b0;
        tick(3);
        RST = 1'b1;
        tick(4);
        check("midrst_busy", 32'(BUSY), 32'h0);
        send_bits(32'h0000_07FF, 11);
        CSb = 1'b1;
        tick(6);
        check("midrst_fe", 32'(fe_cnt - fe0), 32'h0);
        check("midrst_cmd_out", 32'(cmd_if.CMD_OUT), 32'h0);
        open_frame();
        send_bits(32'h0000_5A5A, 16);
        CSb = 1'b1;
        tick(6);
        check("midrst_recover_out", 32'(cmd_if.CMD_OUT), 32'h5A5A);

        // Trigger: 2-cycle latency, single pulse.
        tp0 = tp_cnt;
        TRG_SLV = 1'b1;
        tick(1);
        check("trg_out_cycle1", 32'(TRG_OUT), 32'h0);
        tick(1);
        check("trg_out_cycle2", 32'(TRG_OUT), 32'h1);
        check("trg_pulse_high", 32'(TRG_PULSE), 32'h1);
        tick(8);
        check("trg_pulse_count", 32'(tp_cnt - tp0), 32'h1);
        TRG_SLV = 1'b0;
        tick(3);
        check("trg_out_low", 32'(TRG_OUT), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 Parameter: CMD_W, 16, command word width in bits; the bit counter SHALL be wide enough to hold CMD_W+1.
REQ-002 CLK  input  1  block clock; SHALL run at least 4x the SCLK frequency.
REQ-003 RST  input  1  synchronous, active-low reset.
REQ-004 SCLK  input  1  serial clock from the SPI master, asynchronous to CLK.
REQ-005 CSb  input  1  active-low chip select, asynchronous.
REQ-006 MOSI  input  1  serial data, MSB first, stable while SCLK is high.
REQ-007 RST_SLV  input  1  master-driven soft reset, active high, asynchronous.
REQ-008 TRG_SLV  input  1  master-driven trigger level, asynchronous.
REQ-009 CMD_OUT  output  CMD_W  last accepted command word.
REQ-010 CMD_VALID  output  1  CMD_OUT holds an unacknowledged word.
REQ-011 CMD_ACK  input  1  consumer acknowledge, sampled on CLK.
REQ-012 FRAME_ERR  output  1  one-cycle pulse on a malformed frame.
REQ-013 OVERRUN  output  1  one-cycle pulse when a good frame is dropped because CMD_VALID is still set.
REQ-014 TRG_OUT  output  1  synchronized TRG_SLV level.
REQ-015 TRG_PULSE  output  1  one-cycle pulse on a synchronized TRG_SLV rising edge.
REQ-016 BUSY  output  1  high in state RECV or OVRLEN.

Function
REQ-017 SCLK, CSb, MOSI, RST_SLV and TRG_SLV SHALL each pass through a 2-flop synchronizer; SCLK and CSb SHALL have a third flop for edge detection.
REQ-018 MOSI SHALL be sampled from its synchronizer output on a detected synchronized SCLK rising edge, so it is aligned with SCLK.
REQ-019 States: IDLE, RECV, OVRLEN.
REQ-020 IDLE -> RECV only on a synchronized CSb falling edge; entry SHALL clear the shift register and the bit counter.
REQ-021 If CSb is low when RST is released, the block SHALL stay in IDLE until CSb has been seen high and then falling.
REQ-022 RECV: each SCLK rise SHALL shift the sample in at the LSB (MSB-first word) and increment the counter.
REQ-023 RECV -> OVRLEN on SCLK rise number CMD_W+1.
REQ-024 RECV -> IDLE on a CSb rising edge, with the following outcomes:
  - count == CMD_W: deliver the word.
  - count in 1..CMD_W-1: FRAME_ERR pulse.
  - count == 0: silent, no output.
REQ-025 OVRLEN SHALL ignore SCLK; on a CSb rising edge it SHALL pulse FRAME_ERR and go to IDLE.
REQ-026 Delivery with CMD_VALID low: load CMD_OUT and set CMD_VALID.
REQ-027 Delivery with CMD_VALID high and CMD_ACK low: keep the old word and pulse OVERRUN.
REQ-028 Delivery with CMD_VALID high and CMD_ACK high in the same cycle: load the new word, CMD_VALID stays high, no OVERRUN.
REQ-029 CMD_ACK with CMD_VALID high and no delivery SHALL clear CMD_VALID on the next edge; CMD_ACK with CMD_VALID low SHALL be ignored.
REQ-030 CMD_VALID SHALL rise at the 3rd CLK rising edge that samples CSb high (edge 1 is the first sampling).
REQ-031 CMD_OUT SHALL change only on a delivery.
REQ-032 TRG_OUT SHALL follow TRG_SLV with 2 CLK cycles of latency; TRG_PULSE SHALL be high for exactly one cycle per rising edge of TRG_OUT.
REQ-033 Synchronized RST_SLV high SHALL act as RST for all state except TRG_OUT and TRG_PULSE, for as long as it is high, including mid-frame.

Reset
REQ-034 While RST is low, or per REQ-033, the following SHALL hold:
  - state IDLE;
  - counter 0;
  - shift register 0;
  - CMD_OUT 0;
  - CMD_VALID, FRAME_ERR, OVERRUN, BUSY all 0.
REQ-035 While RST is low, TRG_OUT and TRG_PULSE SHALL be 0 and the synchronizers SHALL clear to CSb=1 and all other inputs 0.
REQ-036 Assertion of RST mid-frame SHALL discard the partial word and raise no FRAME_ERR.

Verification
REQ-037 Frame 0xA5C3, 16 bits, SCLK = CLK/4 -> CMD_OUT=0xA5C3, CMD_VALID high at the 3rd edge after CSb is sampled high, FRAME_ERR=0.
REQ-038 10-bit frame, then a 17-bit frame -> two FRAME_ERR pulses, CMD_VALID stays 0, BUSY is 0 after each.
REQ-039 Frame 0x1234, no ACK, then frame 0xBEEF -> CMD_OUT=0x1234 and one OVERRUN pulse.
REQ-040 Repeat REQ-039 with ACK coincident with the second delivery -> CMD_OUT=0xBEEF, CMD_VALID=1, no OVERRUN.
REQ-041 RST_SLV pulse after 8 bits, then a full frame 0x00FF -> first frame discarded, CMD_OUT=0x00FF.
REQ-042 TRG_SLV 0->1 held high for 10 cycles -> TRG_OUT high after 2 cycles, exactly one TRG_PULSE.
